// File: rtl/packet_sink.sv
// NoC edge sink: credit-managed input FIFO feeding a header/size/payload parser.
// Define PACKET_SINK_CHECKSUM_EN to build the payload XOR checksum.
module packet_sink #(
   parameter int FLIT_SIZE   = 32,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [FLIT_SIZE-1:0] out_data_o,
   output logic                 out_last_o,
   output logic [FLIT_SIZE-1:0] header_o,
   output logic [FLIT_SIZE-1:0] size_o,
   output logic                 pkt_done_o,
   output logic [31:0]          pkt_count_o,
   output logic                 overflow_o,
   output logic [FLIT_SIZE-1:0] checksum_o
);

   localparam int AW = $clog2(BUFFER_SIZE);

   localparam logic [1:0] S_HEADER  = 2'd0;
   localparam logic [1:0] S_SIZE    = 2'd1;
   localparam logic [1:0] S_PAYLOAD = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 empty, full, accept, pop;
   logic [FLIT_SIZE-1:0] head;
   logic [1:0]           state;
   logic [FLIT_SIZE-1:0] remaining;

   assign empty  = (count == '0);
   assign full   = (count == (AW+1)'(BUFFER_SIZE));
   // Credit is withheld while reset is asserted even though the FIFO is empty.
   assign credit_o = !rst_i && !full;
   assign accept   = rx_i && credit_o;
   assign head     = mem[rd_ptr];

   assign out_data_o  = head;
   assign out_valid_o = (state == S_PAYLOAD) && !empty;
   assign out_last_o  = out_valid_o && (remaining == FLIT_SIZE'(1));
   assign pkt_done_o  = (state == S_DONE);

   always_comb begin
      pop = 1'b0;
      case (state)
         S_HEADER, S_SIZE: pop = !empty;
         S_PAYLOAD:        pop = out_valid_o && out_ready_i;
         default:          pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (accept) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (rx_i && !credit_o) overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_HEADER;
         header_o    <= '0;
         size_o      <= '0;
         remaining   <= '0;
         pkt_count_o <= '0;
      end else begin
         case (state)
            S_HEADER: if (!empty) begin
               header_o <= head;
               state    <= S_SIZE;
            end
            S_SIZE: if (!empty) begin
               size_o    <= head;
               remaining <= head;
               state     <= (head == '0) ? S_DONE : S_PAYLOAD;
            end
            S_PAYLOAD: if (pop) begin
               remaining <= remaining - 1'b1;
               if (remaining == FLIT_SIZE'(1)) state <= S_DONE;
            end
            default: begin
               pkt_count_o <= pkt_count_o + 32'd1;
               state       <= S_HEADER;
            end
         endcase
      end
   end

`ifdef PACKET_SINK_CHECKSUM_EN
   logic [FLIT_SIZE-1:0] acc;

   // Result lands in checksum_o on the edge entering DONE, so it is valid while pkt_done_o is high.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc        <= '0;
         checksum_o <= '0;
      end else if (state == S_SIZE && pop) begin
         acc <= '0;
         if (head == '0) checksum_o <= '0;
      end else if (state == S_PAYLOAD && pop) begin
         acc <= acc ^ head;
         if (remaining == FLIT_SIZE'(1)) checksum_o <= acc ^ head;
      end
   end
`else
   assign checksum_o = '0;
`endif

endmodule
